rf_alu_sequencer: RTL and testbench
===================================

// Module: rf_alu_sequencer
// PURPOSE
//  Parametrised register-file + ALU datapath with a command handshake.
//  Executes one command at a time: load immediate, 1-cycle ALU op, or multi-cycle multiply.
//  Multiply is unsigned shift-add, W cycles. Flags are held in a register.
//  Sits between board switch/button decode and the seven-segment/LED outputs.
//  Next step after the single-cycle RegFile+ALU lab datapath.
// PARAMETERS
//  W     4  datapath width in bits (>=2)
//  NREG  4  number of registers; power of two, >=2; AW = $clog2(NREG)
// PORTS
//  Clk       in   1     rising-edge clock
//  Reset     in   1     synchronous, active-high
//  iValid    in   1     command present
//  oReady    out  1     block can accept a command (1 in IDLE)
//  iCmd      in   2     defs::t_cmd: CMD_LOADI / CMD_ALU / CMD_MUL / CMD_NOP
//  iALUop    in   4     ALU op code, defs encoding (CMD_ALU only)
//  iRA1      in   AW    source register 1
//  iRA2      in   AW    source register 2
//  iWA       in   AW    destination register
//  iImm      in   W     immediate (CMD_LOADI only)
//  oDone     out  1     1-cycle pulse: command completed
//  oResult   out  W     value written by last completed command
//  oProdHi   out  W     upper W bits of last MUL product, else 0
//  oFlag     out  4     defs::t_flag {sign,zero,overflow,carryOut}, registered
//  iDbgAddr  in   AW    debug read address
//  oDbgData  out  W     combinational read of RF[iDbgAddr]
// BEHAVIOUR
//  Reset: all registers, oResult, oProdHi, oFlag = 0; oDone = 0; FSM = IDLE; oReady = 1.
//   Reset has priority over every other event.
//  Accept occurs on an edge with iValid & oReady & !Reset. No accept in any other case.
//   iValid held while busy is not consumed.
//  RF read ports are combinational. A write lands at the edge.
//   A command accepted at edge N+1 sees the write made at edge N.
//  LOADI: RF[iWA] <= iImm at the accept edge. oFlag unchanged.
//   oDone=1 and oResult=iImm in the following cycle.
//  ALU: RF[iWA] <= ALU(RF[iRA1], RF[iRA2], iALUop) at the accept edge.
//   oFlag <= ALU flags. oDone next cycle. oReady stays 1, so throughput is 1 cmd/cycle.
//  NOP: no write, no flag change. oDone pulses next cycle.
//  MUL: operands and iWA are latched at accept, so iRA1/iRA2 may equal iWA.
//   FSM IDLE->MUL; oReady=0 for W cycles (counter W-1..0).
//   Each cycle: if mplr[0], acc += mcand; shift {acc,mplr} right.
//   The last MUL cycle writes RF[wa] <= prod[W-1:0]. oProdHi <= prod[2W-1:W]. FSM->IDLE.
//   oDone pulses the next cycle, which is also the first cycle oReady is 1 again.
//   MUL flags: zero=(low==0), sign=low[W-1], carryOut=overflow=(high!=0).
//  Reset mid-MUL aborts the multiply with no write; the FSM returns to IDLE.
//  Arithmetic wraps modulo 2^W. Carry and overflow are taken from the ALU's defs semantics.
//  oProdHi is cleared on any non-MUL completion.
// STRUCTURE
//  defs package gains:
//   t_cmd enum (2 bits)
//   t_seq_state enum {IDLE, MUL}
//  Reuses RegFile #(W) and ALU #(.N(W)) unchanged. RegFile gains NREG depth if it is not already parametrised.
//  One new sub-module: mul_shift_add #(W), with start/busy/done and a 2W product.
// TESTING
//  1. Reset 2 cycles, sweep iDbgAddr -> every oDbgData=0, oReady=1, oDone=0, oFlag=0.
//  2. LOADI r1=5, LOADI r2=3, ALU add r3=r1+r2 on 3 consecutive cycles
//     -> oResult=8, oDone on 3 cycles, r3=8.
//  3. W=4: r1=F, r2=1, ALU add -> oResult=0, zero=1, carryOut=1.
//  4. MUL r1=7 x r2=6 -> oReady=0 for 4 cycles, iValid held meanwhile not accepted,
//     then oResult=A, oProdHi=2, carry=ovf=1.
//  5. Reset asserted on 2nd MUL cycle -> no write (dest stays 0), oReady=1 next cycle, no oDone.
//  6. W=8, NREG=8: r5=FF, MUL r5=r5*r5 -> r5=01, oProdHi=FE, zero=0, sign=0.

Source files
------------

// File: rtl/rf_alu_sequencer_pkg.sv
// Shared types for the register-file/ALU sequencer: command codes, FSM states, flag layout, ALU op codes.
// Pure declarations; no timing or flow-control behaviour.
package rf_alu_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_LOADI = 2'd1,
        CMD_ALU   = 2'd2,
        CMD_MUL   = 2'd3
    } t_cmd;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } t_seq_state;

    typedef struct packed {
        logic sign;
        logic zero;
        logic overflow;
        logic carryOut;
    } t_flag;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;

endpackage

// File: rtl/rf_alu_sequencer_if.sv
// Command/result bundle between switch decode and the sequencer; master drives commands.
// Valid/ready on the command side; results are registered one-cycle pulses.
interface rf_alu_sequencer_if #(
    parameter int W    = 4,
    parameter int NREG = 4,
    localparam int AW  = $clog2(NREG)
);
    import rf_alu_sequencer_pkg::*;

    logic          iValid;
    logic          oReady;
    t_cmd          iCmd;
    logic [3:0]    iALUop;
    logic [AW-1:0] iRA1;
    logic [AW-1:0] iRA2;
    logic [AW-1:0] iWA;
    logic [W-1:0]  iImm;
    logic          oDone;
    logic [W-1:0]  oResult;
    logic [W-1:0]  oProdHi;
    t_flag         oFlag;
    logic [AW-1:0] iDbgAddr;
    logic [W-1:0]  oDbgData;

    modport master (
        output iValid, iCmd, iALUop, iRA1, iRA2, iWA, iImm, iDbgAddr,
        input  oReady, oDone, oResult, oProdHi, oFlag, oDbgData
    );

    modport slave (
        input  iValid, iCmd, iALUop, iRA1, iRA2, iWA, iImm, iDbgAddr,
        output oReady, oDone, oResult, oProdHi, oFlag, oDbgData
    );

endinterface

// File: rtl/rf_alu_sequencer_alu.sv
// Combinational ALU with {sign,zero,overflow,carryOut} flags; SUB reports borrow in carryOut.
// Zero latency; no backpressure.
module ALU
    import rf_alu_sequencer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] iA,
    input  logic [N-1:0] iB,
    input  logic [3:0]   iOp,
    output logic [N-1:0] oY,
    output t_flag        oFlag
);
    logic [N:0] w_ext;

    always_comb begin
        w_ext         = '0;
        oY            = iA;
        oFlag         = '0;
        case (iOp)
            ALU_ADD: begin
                w_ext          = {1'b0, iA} + {1'b0, iB};
                oY             = w_ext[N-1:0];
                oFlag.carryOut = w_ext[N];
                oFlag.overflow = (iA[N-1] == iB[N-1]) && (oY[N-1] != iA[N-1]);
            end
            ALU_SUB: begin
                w_ext          = {1'b0, iA} - {1'b0, iB};
                oY             = w_ext[N-1:0];
                oFlag.carryOut = w_ext[N];
                oFlag.overflow = (iA[N-1] != iB[N-1]) && (oY[N-1] != iA[N-1]);
            end
            ALU_AND: oY = iA & iB;
            ALU_OR:  oY = iA | iB;
            ALU_XOR: oY = iA ^ iB;
            ALU_NOT: oY = ~iA;
            ALU_SHL: begin
                oY             = iA << 1;
                oFlag.carryOut = iA[N-1];
            end
            ALU_SHR: begin
                oY             = iA >> 1;
                oFlag.carryOut = iA[0];
            end
            default: oY = iA;
        endcase
        oFlag.sign = oY[N-1];
        oFlag.zero = (oY == '0);
    end

endmodule

// File: rtl/rf_alu_sequencer_mul.sv
// Unsigned shift-add multiplier: W cycles after start; oDone/oProd are valid combinationally in the last busy cycle.
// Start is ignored while busy.
module mul_shift_add #(
    parameter int W   = 4,
    localparam int CW = $clog2(W)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           iStart,
    input  logic [W-1:0]   iMcand,
    input  logic [W-1:0]   iMplr,
    output logic           oBusy,
    output logic           oDone,
    output logic [2*W-1:0] oProd
);
    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_mplr;
    logic [W:0]    w_sum;

    // oProd is the post-shift {acc,mplr}, so the final step's result is usable before it is registered
    assign w_sum = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
    assign oProd = {w_sum, r_mplr[W-1:1]};
    assign oBusy = r_busy;
    assign oDone = r_busy && (r_cnt == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
        end else if (!r_busy && iStart) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(W - 1);
            r_mcand <= iMcand;
            r_acc   <= '0;
            r_mplr  <= iMplr;
        end else if (r_busy) begin
            r_acc  <= oProd[2*W-1:W];
            r_mplr <= oProd[W-1:0];
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == '0) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_alu_sequencer_rf.sv
// Register file: three combinational read ports, one write port landing at the clock edge.
// Zero read latency; no backpressure.
module RegFile #(
    parameter int W    = 4,
    parameter int NREG = 4,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          iWe,
    input  logic [AW-1:0] iWA,
    input  logic [W-1:0]  iWD,
    input  logic [AW-1:0] iRA1,
    input  logic [AW-1:0] iRA2,
    input  logic [AW-1:0] iRA3,
    output logic [W-1:0]  oRD1,
    output logic [W-1:0]  oRD2,
    output logic [W-1:0]  oRD3
);
    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (iWe) begin
            r_mem[iWA] <= iWD;
        end
    end

    assign oRD1 = r_mem[iRA1];
    assign oRD2 = r_mem[iRA2];
    assign oRD3 = r_mem[iRA3];

endmodule

// File: rtl/rf_alu_sequencer.sv
// Command sequencer over RegFile + ALU + shift-add multiplier; LOADI/ALU/NOP complete 1 cycle after accept, MUL after W+1.
// oReady drops for the W multiply cycles; commands presented meanwhile are held, not consumed.
module rf_alu_sequencer
    import rf_alu_sequencer_pkg::*;
#(
    parameter int W    = 4,
    parameter int NREG = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    rf_alu_sequencer_if.slave bus
);
    localparam int AW = $clog2(NREG);

    t_seq_state     r_state;
    t_seq_state     w_state_nxt;
    logic           w_accept;
    logic           w_mul_start;
    logic           w_mul_busy;
    logic           w_mul_done;
    logic           w_we;
    logic [AW-1:0]  w_wa;
    logic [AW-1:0]  r_wa;
    logic [W-1:0]   w_wd;
    logic [W-1:0]   w_rd1;
    logic [W-1:0]   w_rd2;
    logic [W-1:0]   w_rd3;
    logic [W-1:0]   w_alu_y;
    logic [2*W-1:0] w_prod;
    t_flag          w_alu_flag;
    t_flag          r_flag;
    logic           r_done;
    logic [W-1:0]   r_result;
    logic [W-1:0]   r_prodhi;

    RegFile #(.W(W), .NREG(NREG)) u_rf (
        .Clk (Clk),      .Reset(Reset),     .iWe (w_we),
        .iWA (w_wa),     .iWD  (w_wd),
        .iRA1(bus.iRA1), .iRA2 (bus.iRA2),  .iRA3(bus.iDbgAddr),
        .oRD1(w_rd1),    .oRD2 (w_rd2),     .oRD3(w_rd3)
    );

    ALU #(.N(W)) u_alu (
        .iA(w_rd1), .iB(w_rd2), .iOp(bus.iALUop), .oY(w_alu_y), .oFlag(w_alu_flag)
    );

    mul_shift_add #(.W(W)) u_mul (
        .Clk   (Clk),   .Reset (Reset), .iStart(w_mul_start),
        .iMcand(w_rd1), .iMplr (w_rd2),
        .oBusy (w_mul_busy), .oDone(w_mul_done), .oProd(w_prod)
    );

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_nxt = MUL;
            MUL:     if (w_mul_done)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.oReady  = (r_state == IDLE) && !w_mul_busy;
        w_accept    = bus.iValid && bus.oReady;
        w_mul_start = w_accept && (bus.iCmd == CMD_MUL);
    end

    // Single write port: an accepted LOADI/ALU and a finishing MUL can never coincide
    always_comb begin
        w_we = 1'b0;
        w_wa = bus.iWA;
        w_wd = bus.iImm;
        if (w_accept && bus.iCmd == CMD_LOADI) begin
            w_we = 1'b1;
        end else if (w_accept && bus.iCmd == CMD_ALU) begin
            w_we = 1'b1;
            w_wd = w_alu_y;
        end else if (w_mul_done) begin
            w_we = 1'b1;
            w_wa = r_wa;
            w_wd = w_prod[W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_prodhi <= '0;
            r_flag   <= '0;
            r_wa     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                case (bus.iCmd)
                    CMD_LOADI: begin
                        r_done   <= 1'b1;
                        r_result <= bus.iImm;
                        r_prodhi <= '0;
                    end
                    CMD_ALU: begin
                        r_done   <= 1'b1;
                        r_result <= w_alu_y;
                        r_prodhi <= '0;
                        r_flag   <= w_alu_flag;
                    end
                    CMD_NOP: begin
                        r_done   <= 1'b1;
                        r_prodhi <= '0;
                    end
                    CMD_MUL: r_wa <= bus.iWA;
                    default: r_done <= 1'b0;
                endcase
            end else if (w_mul_done) begin
                r_done          <= 1'b1;
                r_result        <= w_prod[W-1:0];
                r_prodhi        <= w_prod[2*W-1:W];
                r_flag.sign     <= w_prod[W-1];
                r_flag.zero     <= (w_prod[W-1:0] == '0);
                r_flag.overflow <= (w_prod[2*W-1:W] != '0);
                r_flag.carryOut <= (w_prod[2*W-1:W] != '0);
            end
        end
    end

    assign bus.oDone    = r_done;
    assign bus.oResult  = r_result;
    assign bus.oProdHi  = r_prodhi;
    assign bus.oFlag    = r_flag;
    assign bus.oDbgData = w_rd3;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer at W=4/NREG=4 and W=8/NREG=8 with hand-computed results.
module tb_rf_alu_sequencer;
    import rf_alu_sequencer_pkg::*;

    logic Clk  = 1'b0;
    logic rst4 = 1'b1;
    logic rst8 = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    rf_alu_sequencer_if #(.W(4), .NREG(4)) bus4();
    rf_alu_sequencer_if #(.W(8), .NREG(8)) bus8();

    rf_alu_sequencer #(.W(4), .NREG(4)) dut4 (.Clk(Clk), .Reset(rst4), .bus(bus4));
    rf_alu_sequencer #(.W(8), .NREG(8)) dut8 (.Clk(Clk), .Reset(rst8), .bus(bus8));

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue4(input t_cmd c, input logic [3:0] op, input logic [1:0] ra1,
                          input logic [1:0] ra2, input logic [1:0] wa, input logic [3:0] imm);
        bus4.iValid = 1'b1; bus4.iCmd = c; bus4.iALUop = op;
        bus4.iRA1 = ra1; bus4.iRA2 = ra2; bus4.iWA = wa; bus4.iImm = imm;
    endtask

    task automatic issue8(input t_cmd c, input logic [2:0] ra1, input logic [2:0] ra2,
                          input logic [2:0] wa, input logic [7:0] imm);
        bus8.iValid = 1'b1; bus8.iCmd = c; bus8.iALUop = ALU_ADD;
        bus8.iRA1 = ra1; bus8.iRA2 = ra2; bus8.iWA = wa; bus8.iImm = imm;
    endtask

    task automatic test_reset();
        issue4(CMD_NOP, ALU_ADD, 2'd0, 2'd0, 2'd0, 4'h0);
        issue8(CMD_NOP, 3'd0, 3'd0, 3'd0, 8'h00);
        bus4.iValid = 1'b0; bus8.iValid = 1'b0;
        bus4.iDbgAddr = '0; bus8.iDbgAddr = '0;
        rst4 = 1'b1; rst8 = 1'b1;
        step(); step();
        rst4 = 1'b0; rst8 = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus4.iDbgAddr = 2'(a);
            #1;
            n_checks++; if (bus4.oDbgData !== 4'h0) begin n_fail++; $display("FAIL reset_rf4[%0d]: got %h expected 0", a, bus4.oDbgData); end
        end
        for (int a = 0; a < 8; a++) begin
            bus8.iDbgAddr = 3'(a);
            #1;
            n_checks++; if (bus8.oDbgData !== 8'h00) begin n_fail++; $display("FAIL reset_rf8[%0d]: got %h expected 00", a, bus8.oDbgData); end
        end
        n_checks++; if (bus4.oReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus4.oReady); end
        n_checks++; if (bus4.oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus4.oDone); end
        n_checks++; if (bus4.oFlag !== 4'b0000) begin n_fail++; $display("FAIL reset_flag: got %h expected 0", bus4.oFlag); end
        n_checks++; if (bus4.oResult !== 4'h0 || bus4.oProdHi !== 4'h0) begin n_fail++; $display("FAIL reset_result: got %h/%h expected 0/0", bus4.oResult, bus4.oProdHi); end
    endtask

    task automatic test_back_to_back();
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd1, 4'h5);
        step();
        n_checks++; if (bus4.oDone !== 1'b1 || bus4.oResult !== 4'h5) begin n_fail++; $display("FAIL b2b_load1: got done=%b res=%h expected 1/5", bus4.oDone, bus4.oResult); end
        n_checks++; if (bus4.oReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", bus4.oReady); end
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd2, 4'h3);
        step();
        n_checks++; if (bus4.oDone !== 1'b1 || bus4.oResult !== 4'h3) begin n_fail++; $display("FAIL b2b_load2: got done=%b res=%h expected 1/3", bus4.oDone, bus4.oResult); end
        issue4(CMD_ALU, ALU_ADD, 2'd1, 2'd2, 2'd3, 4'h0);
        step();
        n_checks++; if (bus4.oDone !== 1'b1 || bus4.oResult !== 4'h8) begin n_fail++; $display("FAIL b2b_add: got done=%b res=%h expected 1/8", bus4.oDone, bus4.oResult); end
        n_checks++; if (bus4.oFlag !== 4'b1010) begin n_fail++; $display("FAIL b2b_add_flag: got %b expected 1010", bus4.oFlag); end
        bus4.iValid = 1'b0;
        bus4.iDbgAddr = 2'd3;
        step();
        n_checks++; if (bus4.oDone !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_done: got %b expected 0", bus4.oDone); end
        n_checks++; if (bus4.oDbgData !== 4'h8) begin n_fail++; $display("FAIL b2b_r3: got %h expected 8", bus4.oDbgData); end
    endtask

    task automatic test_add_carry();
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd1, 4'hF); step();
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd2, 4'h1); step();
        issue4(CMD_ALU, ALU_ADD, 2'd1, 2'd2, 2'd0, 4'h0); step();
        n_checks++; if (bus4.oResult !== 4'h0) begin n_fail++; $display("FAIL carry_result: got %h expected 0", bus4.oResult); end
        n_checks++; if (bus4.oFlag !== 4'b0101) begin n_fail++; $display("FAIL carry_flag: got %b expected 0101", bus4.oFlag); end
        issue4(CMD_NOP, ALU_SUB, 2'd1, 2'd2, 2'd1, 4'h7); step();
        bus4.iValid = 1'b0;
        bus4.iDbgAddr = 2'd1;
        #1;
        n_checks++; if (bus4.oDone !== 1'b1 || bus4.oFlag !== 4'b0101) begin n_fail++; $display("FAIL nop: got done=%b flag=%b expected 1/0101", bus4.oDone, bus4.oFlag); end
        n_checks++; if (bus4.oDbgData !== 4'hF) begin n_fail++; $display("FAIL nop_nowrite: got %h expected F", bus4.oDbgData); end
    endtask

    task automatic test_mul();
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd1, 4'h7); step();
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd2, 4'h6); step();
        bus4.iDbgAddr = 2'd3;
        issue4(CMD_MUL, ALU_ADD, 2'd1, 2'd2, 2'd3, 4'h0); step();
        issue4(CMD_LOADI, ALU_ADD, 2'd1, 2'd1, 2'd0, 4'h9);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus4.oReady !== 1'b0 || bus4.oDone !== 1'b0) begin n_fail++; $display("FAIL mul_busy[%0d]: got ready=%b done=%b expected 0/0", i, bus4.oReady, bus4.oDone); end
            n_checks++; if (bus4.oDbgData !== 4'h8) begin n_fail++; $display("FAIL mul_early_write[%0d]: got %h expected 8", i, bus4.oDbgData); end
            step();
        end
        bus4.iValid = 1'b0;
        n_checks++; if (bus4.oDone !== 1'b1 || bus4.oReady !== 1'b1) begin n_fail++; $display("FAIL mul_done: got done=%b ready=%b expected 1/1", bus4.oDone, bus4.oReady); end
        n_checks++; if (bus4.oResult !== 4'hA || bus4.oProdHi !== 4'h2) begin n_fail++; $display("FAIL mul_prod: got %h%h expected 2A", bus4.oProdHi, bus4.oResult); end
        n_checks++; if (bus4.oFlag !== 4'b1011) begin n_fail++; $display("FAIL mul_flag: got %b expected 1011", bus4.oFlag); end
        n_checks++; if (bus4.oDbgData !== 4'hA) begin n_fail++; $display("FAIL mul_r3: got %h expected A", bus4.oDbgData); end
        bus4.iDbgAddr = 2'd0;
        #1;
        n_checks++; if (bus4.oDbgData !== 4'h0) begin n_fail++; $display("FAIL mul_held_cmd: got r0=%h expected 0", bus4.oDbgData); end
        issue4(CMD_NOP, ALU_ADD, 2'd0, 2'd0, 2'd0, 4'h0); step();
        bus4.iValid = 1'b0;
        n_checks++; if (bus4.oProdHi !== 4'h0 || bus4.oResult !== 4'hA) begin n_fail++; $display("FAIL nop_prodhi: got hi=%h res=%h expected 0/A", bus4.oProdHi, bus4.oResult); end
    endtask

    task automatic test_mul_reset();
        bus4.iDbgAddr = 2'd0;
        issue4(CMD_MUL, ALU_ADD, 2'd1, 2'd2, 2'd0, 4'h0); step();
        bus4.iValid = 1'b0;
        step();
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        n_checks++; if (bus4.oReady !== 1'b1 || bus4.oDone !== 1'b0) begin n_fail++; $display("FAIL mulrst_state: got ready=%b done=%b expected 1/0", bus4.oReady, bus4.oDone); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (bus4.oDone !== 1'b0 || bus4.oDbgData !== 4'h0) begin n_fail++; $display("FAIL mulrst_after[%0d]: got done=%b r0=%h expected 0/0", i, bus4.oDone, bus4.oDbgData); end
        end
    endtask

    task automatic test_alu_ops();
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd1, 4'h3); step();
        issue4(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd2, 4'h5); step();
        issue4(CMD_ALU, ALU_SUB, 2'd1, 2'd2, 2'd3, 4'h0); step();
        n_checks++; if (bus4.oResult !== 4'hE || bus4.oFlag !== 4'b1001) begin n_fail++; $display("FAIL sub: got res=%h flag=%b expected E/1001", bus4.oResult, bus4.oFlag); end
        issue4(CMD_ALU, ALU_AND, 2'd1, 2'd2, 2'd0, 4'h0); step();
        bus4.iValid = 1'b0;
        n_checks++; if (bus4.oResult !== 4'h1 || bus4.oFlag !== 4'b0000) begin n_fail++; $display("FAIL and: got res=%h flag=%b expected 1/0000", bus4.oResult, bus4.oFlag); end
    endtask

    task automatic test_mul8();
        bus8.iDbgAddr = 3'd5;
        issue8(CMD_LOADI, 3'd0, 3'd0, 3'd5, 8'hFF); step();
        n_checks++; if (bus8.oResult !== 8'hFF) begin n_fail++; $display("FAIL mul8_load: got %h expected FF", bus8.oResult); end
        issue8(CMD_MUL, 3'd5, 3'd5, 3'd5, 8'h00); step();
        bus8.iValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (bus8.oReady !== 1'b0) begin n_fail++; $display("FAIL mul8_busy[%0d]: got %b expected 0", i, bus8.oReady); end
            step();
        end
        n_checks++; if (bus8.oDone !== 1'b1 || bus8.oResult !== 8'h01) begin n_fail++; $display("FAIL mul8_low: got done=%b res=%h expected 1/01", bus8.oDone, bus8.oResult); end
        n_checks++; if (bus8.oProdHi !== 8'hFE) begin n_fail++; $display("FAIL mul8_hi: got %h expected FE", bus8.oProdHi); end
        n_checks++; if (bus8.oFlag !== 4'b0011) begin n_fail++; $display("FAIL mul8_flag: got %b expected 0011", bus8.oFlag); end
        n_checks++; if (bus8.oDbgData !== 8'h01) begin n_fail++; $display("FAIL mul8_r5: got %h expected 01", bus8.oDbgData); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_add_carry();
        test_mul();
        test_mul_reset();
        test_alu_ops();
        test_mul8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
